// File: rtl/queue_pop_stage.sv
// queue_pop_stage: consumer-side front end for the circular FIFO `queue`.
// Pops the queue whenever it is non-empty and the 2-entry output stage has
// room. The popped entries are handed downstream over valid/ready.
// Optional macro QPOP_STATS_EN adds saturating pop and stall counters.
//
// Handshake: an entry moves downstream on any posedge where valid_OUT and
// ready_IN are both high. Once valid_OUT rises, it stays high with data_OUT
// stable until that transfer happens. The exceptions are flush_IN and reset.
// ready_IN is ignored while valid_OUT is low.
module queue_pop_stage #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush_IN,
   input  logic                  q_emptyFlag_IN,
   input  logic [DATA_WIDTH-1:0] q_data_IN,
   output logic                  q_popReq_OUT,
   output logic                  valid_OUT,
   output logic [DATA_WIDTH-1:0] data_OUT,
   input  logic                  ready_IN,
   output logic [1:0]            state_debug
`ifdef QPOP_STATS_EN
   ,
   output logic [COUNT_WIDTH-1:0] popCount_OUT,
   output logic [COUNT_WIDTH-1:0] stallCount_OUT
`endif
);

   // The encoding equals the number of entries held, which makes debug easy to read.
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   logic [1:0]            state, state_nxt;
   logic [DATA_WIDTH-1:0] mainData, skidData;
   logic                  pop, xfer;
   logic                  main_load, main_from_skid, skid_load;

   assign data_OUT     = mainData;
   assign valid_OUT    = (state != S_EMPTY) && !flush_IN;
   // The pop request never looks at ready_IN. The skid register absorbs the one-cycle lag.
   assign q_popReq_OUT = !q_emptyFlag_IN && (state != S_TWO) && !flush_IN && reset;
   assign pop          = q_popReq_OUT;
   assign xfer         = valid_OUT && ready_IN;
   assign state_debug  = state;

   // Next-state and data-register load decisions.
   always_comb begin
      state_nxt      = state;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      case (state)
         S_EMPTY: begin
            if (pop) begin
               state_nxt = S_ONE;
               main_load = 1'b1;
            end
         end
         S_ONE: begin
            if (pop && xfer) begin
               main_load = 1'b1;
            end else if (pop) begin
               state_nxt = S_TWO;
               skid_load = 1'b1;
            end else if (xfer) begin
               state_nxt = S_EMPTY;
            end
         end
         S_TWO: begin
            if (xfer) begin
               state_nxt      = S_ONE;
               main_from_skid = 1'b1;
            end
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   // State and data registers. Reset clears everything. Flush only empties the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_EMPTY;
         mainData <= '0;
         skidData <= '0;
      end else if (flush_IN) begin
         state <= S_EMPTY;
      end else begin
         state <= state_nxt;
         if (main_load)      mainData <= q_data_IN;
         if (main_from_skid) mainData <= skidData;
         if (skid_load)      skidData <= q_data_IN;
      end
   end

`ifdef QPOP_STATS_EN
   logic [COUNT_WIDTH-1:0] pop_cnt, stall_cnt;
   assign popCount_OUT   = pop_cnt;
   assign stallCount_OUT = stall_cnt;

   // Saturating statistics counters. Flush does not affect them.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pop_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop && (pop_cnt != '1))
            pop_cnt <= pop_cnt + 1'b1;
         if (valid_OUT && !ready_IN && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end
`else
   // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_queue_pop_stage.sv
// Bench for queue_pop_stage. It emulates the attached queue with a queue
// variable and predicts every output from a reference model of the held
// entries, which is a FIFO of at most two items. Define QPOP_STATS_EN to
// also check the counters.
module tb_queue_pop_stage;
   localparam int DW = 8;
`ifdef QPOP_STATS_EN
   localparam int CW = 2;
`else
   localparam int CW = 16;
`endif

   logic          clk = 1'b0;
   logic          reset, flush_IN, q_emptyFlag_IN, ready_IN;
   logic [DW-1:0] q_data_IN, data_OUT;
   logic          q_popReq_OUT, valid_OUT;
   logic [1:0]    state_debug;
`ifdef QPOP_STATS_EN
   logic [CW-1:0] popCount_OUT, stallCount_OUT;
   int            m_pops, m_stalls;
`endif

   queue_pop_stage #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .flush_IN(flush_IN),
      .q_emptyFlag_IN(q_emptyFlag_IN), .q_data_IN(q_data_IN),
      .q_popReq_OUT(q_popReq_OUT), .valid_OUT(valid_OUT),
      .data_OUT(data_OUT), .ready_IN(ready_IN), .state_debug(state_debug)
`ifdef QPOP_STATS_EN
      , .popCount_OUT(popCount_OUT), .stallCount_OUT(stallCount_OUT)
`endif
   );

   // Clock and reset.
   always #5 clk = ~clk;

   // Scoreboard state.
   logic [DW-1:0] src_q[$];   // contents of the emulated queue
   logic [DW-1:0] exp_q[$];   // entries the stage should be holding, in order
   logic [DW-1:0] exp_data;   // the last entry presented on data_OUT
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive the inputs, check the outputs before the edge,
   // then advance the model.
   task automatic step(input logic rst_v, input logic flush_v, input logic rdy_v);
      logic e_valid, e_pop, d_pop;
      logic [DW-1:0] head;
      @(negedge clk);
      reset          = rst_v;
      flush_IN       = flush_v;
      ready_IN       = rdy_v;
      q_emptyFlag_IN = (src_q.size() == 0);
      head           = (src_q.size() != 0) ? src_q[0] : DW'($urandom);
      q_data_IN      = head;
      #1;
      e_valid = (exp_q.size() != 0) && !flush_v;
      e_pop   = (src_q.size() != 0) && (exp_q.size() < 2) && !flush_v && rst_v;
      check_eq("valid", {31'd0, valid_OUT}, {31'd0, e_valid});
      check_eq("data", {24'd0, data_OUT}, {24'd0, exp_data});
      check_eq("pop_req", {31'd0, q_popReq_OUT}, {31'd0, e_pop});
      check_eq("held", {30'd0, state_debug}, exp_q.size());
`ifdef QPOP_STATS_EN
      check_eq("pop_cnt", {30'd0, popCount_OUT}, (m_pops > 3) ? 3 : m_pops);
      check_eq("stall_cnt", {30'd0, stallCount_OUT}, (m_stalls > 3) ? 3 : m_stalls);
`endif
      d_pop = q_popReq_OUT;
      @(posedge clk);
      // The emulated queue follows the pop request that the DUT actually issued.
      if (d_pop && src_q.size() != 0) void'(src_q.pop_front());
`ifdef QPOP_STATS_EN
      if (!rst_v) begin
         m_pops = 0; m_stalls = 0;
      end else begin
         if (e_pop) m_pops++;
         if (e_valid && !rdy_v) m_stalls++;
      end
`endif
      if (!rst_v) begin
         exp_q.delete();
         exp_data = '0;
      end else if (flush_v) begin
         exp_q.delete();
      end else begin
         if (e_valid && rdy_v) void'(exp_q.pop_front());
         if (e_pop) exp_q.push_back(head);
         if (exp_q.size() != 0) exp_data = exp_q[0];
      end
   endtask

   task automatic push(input logic [DW-1:0] v);
      src_q.push_back(v);
   endtask

   initial begin
      reset = 1'b0; flush_IN = 1'b0; q_emptyFlag_IN = 1'b1;
      q_data_IN = '0; ready_IN = 1'b0;
      exp_data = '0;
`ifdef QPOP_STATS_EN
      m_pops = 0; m_stalls = 0;
`endif
      @(posedge clk);
      // Reset, then idle with the queue empty.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      // Streaming three entries with downstream always ready.
      push(8'h11); push(8'h22); push(8'h33);
      repeat (5) step(1'b1, 1'b0, 1'b1);
      // Backpressure: ready low for 4 cycles, then release.
      for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
      repeat (4) step(1'b1, 1'b0, 1'b0);
      repeat (7) step(1'b1, 1'b0, 1'b1);
      // Flush while both registers are full, then push a new entry.
      push(8'h05); push(8'h06);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      push(8'h07);
      repeat (3) step(1'b1, 1'b0, 1'b1);
      // Reset while one entry is held.
      push(8'h99);
      repeat (2) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b1);
      // Random traffic: bursty pushes, random ready, rare flush and reset.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) != 0 && src_q.size() < 8) push(DW'($urandom));
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 2) != 0));
      end
      // Drain whatever is left.
      repeat (12) step(1'b1, 1'b0, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
